// File: rtl/dma_cmd_arbiter_pkg.sv
// Shared debug-DMA types (libdebug slice) used by the command arbiter:
// command interface record, DMA opcode encoding and arbiter state.
package dma_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    DMA_OP_NOP  = 2'd0,
    DMA_OP_RD   = 2'd1,
    DMA_OP_WR   = 2'd2,
    DMA_OP_FILL = 2'd3
  } dma_OP;

  typedef struct packed {
    logic [3:0]  tid;
    logic [31:0] addr_reg;
    logic [31:0] ctrl_reg;
    logic        addr_we;
    logic        ctrl_we;
  } debug_dma_cmdif_in_type;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } dma_arb_state_type;

  // ctrl_reg layout: [17:16] opcode, [15:0] transfer count
  function automatic logic [31:0] dma_ctrl_word(input dma_OP op, input logic [15:0] count);
    return {14'd0, op, count};
  endfunction

endpackage

// File: rtl/dma_cmd_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each acked-but-not-done
// DMA command. Show-ahead head, simultaneous push/pop allowed even when full.
module dma_tag_fifo
  import dma_cmd_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a full FIFO can only take a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // tag storage, no reset needed: occupancy tracking guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_cmd_arbiter.sv
// Round-robin arbiter sharing one debug DMA command port between NREQ
// requesters. Completions return in issue order and are steered back to the
// owner through an in-order tag FIFO.
// Build option: DMA_ARB_PRIO0_EN gives requester 0 strict priority; the
// remaining requesters round-robin among themselves.
module dma_cmd_arbiter
  import dma_cmd_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NREQ-1:0]                     req_valid,
  input  debug_dma_cmdif_in_type [NREQ-1:0]   req_cmd,
  output logic [NREQ-1:0]                     req_ack,
  output logic [NREQ-1:0]                     req_done,
  output debug_dma_cmdif_in_type              dma_cmd_in,
  input  logic                                dma_cmd_ack,
  input  logic                                dma_done,
  output logic [$clog2(DEPTH):0]              outstanding,
  output logic                                busy,
  output logic                                err_underflow
);

  localparam int GW = $clog2(NREQ);

  dma_arb_state_type state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     rr_next;
  logic [GW-1:0]     next_grant;
  logic [GW-1:0]     idx_g;
  logic              grant_found;
  int                idx;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [GW-1:0]     fifo_head;

  // pick the first valid requester at or after rr_ptr, cyclically
  always_comb begin
    next_grant  = '0;
    grant_found = 1'b0;
    idx         = 0;
    idx_g       = '0;
`ifdef DMA_ARB_PRIO0_EN
    if (req_valid[0]) grant_found = 1'b1;
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NREQ;
      idx_g = GW'(idx);
`ifdef DMA_ARB_PRIO0_EN
      if (!grant_found && req_valid[idx_g] && (idx != 0)) begin
`else
      if (!grant_found && req_valid[idx_g]) begin
`endif
        next_grant  = idx_g;
        grant_found = 1'b1;
      end
    end
  end

  // next round-robin start point after the current grant
  always_comb begin
    rr_next = (int'(grant) == NREQ - 1) ? '0 : grant + GW'(1);
  end

  assign fifo_push = (state == ARB_ISSUE) && dma_cmd_ack;
  assign fifo_pop  = dma_done && !fifo_empty;
  assign busy      = (state != ARB_IDLE) || (outstanding != '0);

  // acknowledge the owner in the same cycle the DMA controller accepts
  always_comb begin
    req_ack = '0;
    if (fifo_push) req_ack[grant] = 1'b1;
  end

  // arbitration FSM: latch winner's command, hold it until the DMA acks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      dma_cmd_in <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_found && !fifo_full) begin
            grant              <= next_grant;
            dma_cmd_in         <= req_cmd[next_grant];
            dma_cmd_in.addr_we <= 1'b1;
            dma_cmd_in.ctrl_we <= 1'b1;
            state              <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (dma_cmd_ack) begin
            dma_cmd_in.addr_we <= 1'b0;
            dma_cmd_in.ctrl_we <= 1'b0;
            state              <= ARB_IDLE;
`ifdef DMA_ARB_PRIO0_EN
            // a requester-0 win does not disturb the rotation of the others
            if (grant != '0) rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // completion steering and sticky underflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_done      <= '0;
      err_underflow <= 1'b0;
    end else begin
      req_done <= '0;
      if (fifo_pop) req_done[fifo_head] <= 1'b1;
      if (dma_done && fifo_empty) err_underflow <= 1'b1;
    end
  end

  dma_tag_fifo #(
    .WIDTH (GW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (grant),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule

// File: tb/tb_dma_cmd_arbiter.sv
// Bench for dma_cmd_arbiter: transaction-level model (tag queue, rotation
// pointer, pending command) checked against the DUT every cycle, plus
// directed scenarios with literal expectations.
module tb_dma_cmd_arbiter;
  import dma_cmd_arbiter_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 8;

  logic                              clk;
  logic                              reset;
  logic [NREQ-1:0]                   req_valid;
  debug_dma_cmdif_in_type [NREQ-1:0] req_cmd;
  logic [NREQ-1:0]                   req_ack;
  logic [NREQ-1:0]                   req_done;
  debug_dma_cmdif_in_type            dma_cmd_in;
  logic                              dma_cmd_ack;
  logic                              dma_done;
  logic [$clog2(DEPTH):0]            outstanding;
  logic                              busy;
  logic                              err_underflow;

  int errors = 0;
  int checks = 0;

  dma_cmd_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_cmd       (req_cmd),
    .req_ack       (req_ack),
    .req_done      (req_done),
    .dma_cmd_in    (dma_cmd_in),
    .dma_cmd_ack   (dma_cmd_ack),
    .dma_done      (dma_done),
    .outstanding   (outstanding),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                     tagq[$];
  int                     m_rr      = 0;
  bit                     m_issuing = 1'b0;
  int                     m_grant   = 0;
  bit                     m_err     = 1'b0;
  logic [NREQ-1:0]        m_done    = '0;
  debug_dma_cmdif_in_type m_cmd     = '0;

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
`ifdef DMA_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < NREQ; k++) begin
      int i = (rr + k) % NREQ;
      if (i != 0 && v[i]) return i;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      int i = (rr + k) % NREQ;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        tagq.delete();
        m_rr      = 0;
        m_issuing = 1'b0;
        m_grant   = 0;
        m_err     = 1'b0;
        m_done    = '0;
        m_cmd     = '0;
      end else begin
        int               size0;
        int               g;
        logic [NREQ-1:0]  nd;
        size0 = tagq.size();
        nd    = '0;
        if (dma_done) begin
          if (size0 > 0) nd[tagq.pop_front()] = 1'b1;
          else m_err = 1'b1;
        end
        if (m_issuing) begin
          if (dma_cmd_ack) begin
            tagq.push_back(m_grant);
`ifdef DMA_ARB_PRIO0_EN
            if (m_grant != 0) m_rr = (m_grant + 1) % NREQ;
`else
            m_rr = (m_grant + 1) % NREQ;
`endif
            m_issuing     = 1'b0;
            m_cmd.addr_we = 1'b0;
            m_cmd.ctrl_we = 1'b0;
          end
        end else if (size0 < DEPTH) begin
          g = pick(req_valid, m_rr);
          if (g >= 0) begin
            m_grant       = g;
            m_issuing     = 1'b1;
            m_cmd         = req_cmd[g];
            m_cmd.addr_we = 1'b1;
            m_cmd.ctrl_we = 1'b1;
          end
        end
        m_done = nd;
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        logic [NREQ-1:0] exp_ack;
        exp_ack = '0;
        if (m_issuing && dma_cmd_ack) exp_ack[m_grant] = 1'b1;
        check("dma_cmd_in", 80'(dma_cmd_in), 80'(m_cmd));
        check("req_ack", 80'(req_ack), 80'(exp_ack));
        check("req_done", 80'(req_done), 80'(m_done));
        check("outstanding", 80'(outstanding), 80'(tagq.size()));
        check("busy", 80'(busy), 80'(m_issuing || tagq.size() != 0));
        check("err_underflow", 80'(err_underflow), 80'(m_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid   = '0;
    dma_cmd_ack = 1'b0;
    dma_done    = 1'b0;
    reset       = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  logic [69:0] exp_cmd_a;
  logic [15:0] order;
  int          n_seen;
  logic [15:0] exp_order;

  initial begin
    req_cmd[0] = '{tid: 4'h1, addr_reg: 32'h0000_1000,
                   ctrl_reg: dma_ctrl_word(DMA_OP_RD, 16'd16), addr_we: 1'b0, ctrl_we: 1'b0};
    req_cmd[1] = '{tid: 4'h2, addr_reg: 32'h0000_2040,
                   ctrl_reg: dma_ctrl_word(DMA_OP_WR, 16'd64), addr_we: 1'b0, ctrl_we: 1'b0};
    exp_cmd_a  = {4'h1, 32'h0000_1000, 32'h0001_0010, 2'b11};
    do_reset();

    check("reset_cmd", 80'(dma_cmd_in), 80'd0);
    check("reset_outstanding", 80'(outstanding), 80'd0);
    check("reset_busy", 80'(busy), 80'd0);
    check("reset_err", 80'(err_underflow), 80'd0);

    // single command, ack three cycles after the write enables rise
    req_valid = 2'b01;
    tick(); check("t1_cmd_c1", 80'(dma_cmd_in), 80'(exp_cmd_a));
    tick(); check("t1_cmd_c2", 80'(dma_cmd_in), 80'(exp_cmd_a));
    tick(); check("t1_cmd_c3", 80'(dma_cmd_in), 80'(exp_cmd_a));
    dma_cmd_ack = 1'b1;
    #1;
    check("t1_ack", 80'(req_ack), 80'd1);
    check("t1_out_pre", 80'(outstanding), 80'd0);
    tick();
    dma_cmd_ack = 1'b0;
    req_valid   = '0;
    check("t1_out_one", 80'(outstanding), 80'd1);
    check("t1_we_clr", 80'({dma_cmd_in.addr_we, dma_cmd_in.ctrl_we}), 80'd0);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("t1_done", 80'(req_done), 80'd1);
    check("t1_out_zero", 80'(outstanding), 80'd0);
    tick();
    check("t1_done_pulse", 80'(req_done), 80'd0);

    // two requesters held valid, immediate acks
    do_reset();
    req_valid   = 2'b11;
    dma_cmd_ack = 1'b1;
    order       = '0;
    n_seen      = 0;
    for (int c = 0; c < 30 && n_seen < 4; c++) begin
      tick();
      if (req_ack != '0) begin
        order[n_seen*4 +: 4] = req_ack[1] ? 4'd1 : 4'd0;
        n_seen++;
      end
    end
    req_valid = '0;
    check("t2_ack_count", 80'(n_seen), 80'd4);
`ifdef DMA_ARB_PRIO0_EN
    exp_order = 16'h0000;
`else
    exp_order = 16'h1010;
`endif
    check("t2_grant_order", 80'(order), 80'(exp_order));
    tick();
    dma_cmd_ack = 1'b0;
    order       = '0;
    n_seen      = 0;
    for (int c = 0; c < 6; c++) begin
      dma_done = (c < 4);
      tick();
      if (req_done != '0 && n_seen < 4) begin
        order[n_seen*4 +: 4] = req_done[1] ? 4'd1 : 4'd0;
        n_seen++;
      end
    end
    dma_done = 1'b0;
    check("t2_done_count", 80'(n_seen), 80'd4);
    check("t2_done_order", 80'(order), 80'(exp_order));

    // fill the tag FIFO, ninth request must wait for a completion
    do_reset();
    req_valid   = 2'b11;
    dma_cmd_ack = 1'b1;
    for (int c = 0; c < 60 && tagq.size() < DEPTH; c++) tick();
    check("t3_fill", 80'(tagq.size()), 80'(DEPTH));
    tick(3);
    check("t3_full_out", 80'(outstanding), 80'd8);
    check("t3_full_busy", 80'(busy), 80'd1);
    check("t3_no_grant", 80'(dma_cmd_in.addr_we), 80'd0);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("t3_after_pop", 80'(outstanding), 80'd7);
    tick();
    check("t3_regrant", 80'(dma_cmd_in.addr_we), 80'd1);
    // completion coincides with the accept: occupancy unchanged
    dma_done  = 1'b1;
    req_valid = '0;
    tick();
    dma_done    = 1'b0;
    dma_cmd_ack = 1'b0;
    check("t4_same_cycle", 80'(outstanding), 80'd7);
    for (int c = 0; c < 20 && tagq.size() > 0; c++) begin
      dma_done = 1'b1;
      tick();
    end
    dma_done = 1'b0;
    tick();
    check("t4_drained", 80'(outstanding), 80'd0);

    // completion with nothing outstanding
    do_reset();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("t5_err_set", 80'(err_underflow), 80'd1);
    check("t5_no_done", 80'(req_done), 80'd0);
    tick(3);
    check("t5_err_sticky", 80'(err_underflow), 80'd1);
    do_reset();
    check("t5_err_cleared", 80'(err_underflow), 80'd0);

    // asynchronous reset while a command is being issued
    req_valid = 2'b10;
    tick(2);
    check("t6_issuing", 80'(dma_cmd_in.addr_we), 80'd1);
    reset = 1'b0;
    #1;
    check("t6_async_cmd", 80'(dma_cmd_in), 80'd0);
    check("t6_async_out", 80'(outstanding), 80'd0);
    check("t6_async_busy", 80'(busy), 80'd0);
    req_valid = '0;
    tick();
    reset = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
